// File: rtl/uop_buffer_pkg.sv
// Shared types for the microcode uop store and its fill sequencer.
package uop_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } uop_fill_state_t;

endpackage

// File: rtl/uop_fill_ctrl.sv
// Fill burst sequencer: walks wr_ptr from the burst base and counts down remaining beats.
module uop_fill_ctrl
  import uop_buffer_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fill_start,
  input  logic [AW-1:0] fill_base,
  input  logic [AW:0]   fill_len,
  input  logic          fill_valid,
  output logic          fill_ready,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr
);

  uop_fill_state_t state_reg, state_next;
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW:0]     remaining_reg, remaining_next;
  logic            fill_done_reg;

  assign fill_ready = (state_reg == FILL);
  assign fill_busy  = (state_reg != IDLE);
  assign fill_done  = fill_done_reg;
  // A beat arriving in the reset cycle belongs to an abandoned burst.
  assign wr_en      = (state_reg == FILL) && fill_valid && !reset;
  assign wr_addr    = wr_ptr_reg;

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    remaining_next = remaining_reg;
    case (state_reg)
      IDLE: begin
        if (fill_start) begin
          wr_ptr_next    = fill_base;
          remaining_next = fill_len;
          state_next     = (fill_len == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (wr_en) begin
          // AW-bit pointer wraps naturally since the store is a power of two.
          wr_ptr_next    = wr_ptr_reg + AW'(1);
          remaining_next = remaining_reg - (AW+1)'(1);
          if (remaining_reg == (AW+1)'(1)) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      remaining_reg <= '0;
      fill_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      remaining_reg <= remaining_next;
      fill_done_reg <= (state_next == DONE);
    end
  end

endmodule

// File: rtl/uop_buffer.sv
// Microcode uop store: registered read port for uop_fetch plus a burst fill port.
`ifndef UOP_BUF_SIZE
`define UOP_BUF_SIZE 16
`endif
`ifndef UOP_BUF_WIDTH
`define UOP_BUF_WIDTH 32
`endif

module uop_buffer
  import uop_buffer_pkg::*;
#(
  parameter int  UOP_BUF_SIZE  = `UOP_BUF_SIZE,
  parameter int  UOP_BUF_WIDTH = `UOP_BUF_WIDTH,
  localparam int AW            = $clog2(UOP_BUF_SIZE)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [AW-1:0]            uop_addr,
  output logic [UOP_BUF_WIDTH-1:0] uop,
  output logic                     uop_valid,
  input  logic                     invalidate,
  input  logic                     fill_start,
  input  logic [AW-1:0]            fill_base,
  input  logic [AW:0]              fill_len,
  input  logic                     fill_valid,
  input  logic [UOP_BUF_WIDTH-1:0] fill_data,
  output logic                     fill_ready,
  output logic                     fill_busy,
  output logic                     fill_done
);

  logic [UOP_BUF_WIDTH-1:0] mem [UOP_BUF_SIZE];
  logic [UOP_BUF_SIZE-1:0]  vld_reg;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic                     wr_hit;

  uop_fill_ctrl #(.AW(AW)) u_fill_ctrl (
    .clk        (clk),
    .reset      (reset),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .fill_len   (fill_len),
    .fill_valid (fill_valid),
    .fill_ready (fill_ready),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr)
  );

  assign wr_hit = wr_en && (wr_addr == uop_addr);

  // Storage is never reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= fill_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_reg <= '0;
    end else begin
      if (invalidate) vld_reg <= '0;
      if (wr_en)      vld_reg[wr_addr] <= 1'b1;
    end
  end

  // Same-cycle write bypass wins over both the stale entry and an invalidate.
  always_ff @(posedge clk) begin
    if (reset) begin
      uop       <= '0;
      uop_valid <= 1'b0;
    end else begin
      uop       <= wr_hit ? fill_data : mem[uop_addr];
      uop_valid <= wr_hit || (!invalidate && vld_reg[uop_addr]);
    end
  end

endmodule
